// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - control-record types and constants shared by the hazard tracker
// Contents: ctrl_entry_t in-flight instruction record, BUBBLE, EPC_ADDR, TNEW_NONE,
//           age_entry() one-stage Tnew aging helper.
package pipe_ctrl_pkg;

    // Record field widths; the tracker's REG_W/TNEW_W/RSEL_W must match these.
    localparam int ENTRY_REG_W  = 5;
    localparam int ENTRY_TNEW_W = 3;
    localparam int ENTRY_RSEL_W = 3;

    // CP0 register number of EPC; eret must not overtake a pending mtc0 to it.
    localparam logic [ENTRY_REG_W-1:0]  EPC_ADDR  = 5'd14;
    // Decoder-side code for "produces no result".
    localparam logic [ENTRY_TNEW_W-1:0] TNEW_NONE = 3'b111;

    typedef struct packed {
        logic                    valid;    // holds a real GPR writer
        logic [ENTRY_REG_W-1:0]  wr_addr;
        logic [ENTRY_TNEW_W-1:0] tnew;     // cycles until result is available
        logic [ENTRY_RSEL_W-1:0] rsel;     // carried unchanged for the forwarding muxes
        logic                    mtc0;     // tracked regardless of valid
        logic [ENTRY_REG_W-1:0]  rd;
        logic                    md;       // mult/div class, independent of rsel
    } ctrl_entry_t;

    localparam ctrl_entry_t BUBBLE = '0;

    // Result moves one stage closer: Tnew counts down and stops at zero.
    function automatic ctrl_entry_t age_entry(input ctrl_entry_t e);
        ctrl_entry_t r;
        r = e;
        if (e.tnew != '0) begin
            r.tnew = e.tnew - 1'b1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipe_ctrl_entry_reg.sv
// rtl/pipe_ctrl_entry_reg.sv - one pipeline control-record register with reset/flush/load and aging
// Ports: clk, reset (sync, active-high), flush (clear to bubble), load (capture d),
//        d (incoming record), q (held record). AGE=1 decrements Tnew on capture.
module pipe_ctrl_entry_reg
    import pipe_ctrl_pkg::*;
#(
    parameter bit AGE = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        load,
    input  ctrl_entry_t d,
    output ctrl_entry_t q
);

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            q <= BUBBLE;
        end else if (load) begin
            q <= AGE ? age_entry(d) : d;
        end
    end

endmodule

// File: rtl/pipe_hazard_tracker.sv
// rtl/pipe_hazard_tracker.sv - shift structure of in-flight control records with D-stage stall logic
// Inputs : clk, reset, flush, D-stage record (d_wr_en/addr/tnew/rsel/mtc0/rd/eret/md),
//          D sources (d_rs/rt, d_use_rs/rt, d_tuse_rs/rt), md_busy.
// Outputs: stall_d, per-stage st_valid/st_wr_addr/st_rsel/st_fwd_ok (stage 0 in LSBs),
//          saturating stall_cnt.
module pipe_hazard_tracker
    import pipe_ctrl_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 5,
    parameter int TNEW_W     = 3,
    parameter int RSEL_W     = 3,
    parameter int CNT_W      = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic                         d_wr_en,
    input  logic [REG_W-1:0]             d_wr_addr,
    input  logic [TNEW_W-1:0]            d_tnew,
    input  logic [RSEL_W-1:0]            d_rsel,
    input  logic                         d_mtc0,
    input  logic [REG_W-1:0]             d_rd,
    input  logic                         d_eret,
    input  logic [REG_W-1:0]             d_rs,
    input  logic [REG_W-1:0]             d_rt,
    input  logic                         d_use_rs,
    input  logic                         d_use_rt,
    input  logic [TNEW_W-1:0]            d_tuse_rs,
    input  logic [TNEW_W-1:0]            d_tuse_rt,
    input  logic                         d_md,
    input  logic                         md_busy,
    output logic                         stall_d,
    output logic [NUM_STAGES-1:0]        st_valid,
    output logic [NUM_STAGES*REG_W-1:0]  st_wr_addr,
    output logic [NUM_STAGES*RSEL_W-1:0] st_rsel,
    output logic [NUM_STAGES-1:0]        st_fwd_ok,
    output logic [CNT_W-1:0]             stall_cnt
);

    ctrl_entry_t st [NUM_STAGES];
    ctrl_entry_t d_rec;
    ctrl_entry_t st0_in;
    logic        haz_rs, haz_rt, epc_pending, md_haz;

    always_comb begin
        d_rec         = BUBBLE;
        d_rec.valid   = d_wr_en && (d_wr_addr != '0);   // $0 writes never create hazards
        d_rec.wr_addr = d_wr_addr;
        d_rec.tnew    = d_tnew;
        d_rec.rsel    = d_rsel;
        d_rec.mtc0    = d_mtc0;
        d_rec.rd      = d_rd;
        d_rec.md      = d_md;
        st0_in        = stall_d ? BUBBLE : d_rec;
    end

    // Stage 0 captures D without aging (Tnew is quoted at stage 0); later stages age.
    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            pipe_ctrl_entry_reg #(.AGE(1'b0)) u_entry (
                .clk(clk), .reset(reset), .flush(flush), .load(1'b1),
                .d(st0_in), .q(st[k])
            );
        end else begin : g_next
            pipe_ctrl_entry_reg #(.AGE(1'b1)) u_entry (
                .clk(clk), .reset(reset), .flush(flush), .load(1'b1),
                .d(st[k-1]), .q(st[k])
            );
        end
    end

    // Single OR across all stages; no stage ordering is needed for the stall decision.
    always_comb begin
        haz_rs      = 1'b0;
        haz_rt      = 1'b0;
        epc_pending = 1'b0;
        st_valid    = '0;
        st_fwd_ok   = '0;
        st_wr_addr  = '0;
        st_rsel     = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (st[k].valid && d_use_rs && (st[k].wr_addr == d_rs) && (st[k].tnew > d_tuse_rs)) begin
                haz_rs = 1'b1;
            end
            if (st[k].valid && d_use_rt && (st[k].wr_addr == d_rt) && (st[k].tnew > d_tuse_rt)) begin
                haz_rt = 1'b1;
            end
            if (st[k].mtc0 && (st[k].rd == EPC_ADDR)) begin
                epc_pending = 1'b1;
            end
            st_valid[k]                   = st[k].valid;
            st_fwd_ok[k]                  = st[k].valid && (st[k].tnew == '0);
            st_wr_addr[k*REG_W +: REG_W]  = st[k].wr_addr;
            st_rsel[k*RSEL_W +: RSEL_W]   = st[k].rsel;
        end
        // A mult/div op just issued to E has not yet raised md_busy.
        md_haz  = d_md && (md_busy || st[0].md);
        stall_d = haz_rs || haz_rt || (d_eret && epc_pending) || md_haz;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_cnt <= '0;
        end else if (stall_d && !flush && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_tracker.sv
// tb/tb_pipe_hazard_tracker.sv - scoreboard bench for pipe_hazard_tracker (3-stage and 5-stage instances)
module tb_pipe_hazard_tracker;

    logic        clk = 1'b0;
    logic        reset, flush;
    logic        d_wr_en, d_mtc0, d_eret, d_use_rs, d_use_rt, d_md, md_busy;
    logic [4:0]  d_wr_addr, d_rd, d_rs, d_rt;
    logic [2:0]  d_tnew, d_rsel, d_tuse_rs, d_tuse_rt;

    logic        stall_d_a;
    logic [2:0]  st_valid_a, st_fwd_ok_a, st_rsel_a_unused;
    logic [14:0] st_wr_addr_a;
    logic [8:0]  st_rsel_a;
    logic [31:0] stall_cnt_a;

    logic        stall_d_b;
    logic [4:0]  st_valid_b, st_fwd_ok_b;
    logic [24:0] st_wr_addr_b;
    logic [14:0] st_rsel_b;
    logic [2:0]  stall_cnt_b;

    typedef struct packed {
        logic        stall;
        logic [2:0]  valid;
        logic [2:0]  fwd;
        logic [14:0] addr;
        logic [31:0] cnt;
    } exp_a_t;

    typedef struct packed {
        logic        stall;
        logic [4:0]  valid;
        logic [2:0]  cnt;
    } exp_b_t;

    exp_a_t sb_a[$];
    exp_b_t sb_b[$];
    int     n_cmp = 0;
    int     n_bad = 0;

    always #5 clk = ~clk;

    pipe_hazard_tracker #(.NUM_STAGES(3)) u_dut_a (
        .clk(clk), .reset(reset), .flush(flush),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_rsel(d_rsel),
        .d_mtc0(d_mtc0), .d_rd(d_rd), .d_eret(d_eret),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_md(d_md), .md_busy(md_busy),
        .stall_d(stall_d_a), .st_valid(st_valid_a), .st_wr_addr(st_wr_addr_a),
        .st_rsel(st_rsel_a), .st_fwd_ok(st_fwd_ok_a), .stall_cnt(stall_cnt_a)
    );

    pipe_hazard_tracker #(.NUM_STAGES(5), .CNT_W(3)) u_dut_b (
        .clk(clk), .reset(reset), .flush(flush),
        .d_wr_en(d_wr_en), .d_wr_addr(d_wr_addr), .d_tnew(d_tnew), .d_rsel(d_rsel),
        .d_mtc0(d_mtc0), .d_rd(d_rd), .d_eret(d_eret),
        .d_rs(d_rs), .d_rt(d_rt), .d_use_rs(d_use_rs), .d_use_rt(d_use_rt),
        .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_md(d_md), .md_busy(md_busy),
        .stall_d(stall_d_b), .st_valid(st_valid_b), .st_wr_addr(st_wr_addr_b),
        .st_rsel(st_rsel_b), .st_fwd_ok(st_fwd_ok_b), .stall_cnt(stall_cnt_b)
    );

    assign st_rsel_a_unused = st_rsel_a[2:0];

    function automatic exp_a_t mk_a(input logic s, input logic [2:0] v, input logic [2:0] f,
                                    input logic [14:0] a, input logic [31:0] c);
        return '{stall: s, valid: v, fwd: f, addr: a, cnt: c};
    endfunction

    function automatic exp_b_t mk_b(input logic s, input logic [4:0] v, input logic [2:0] c);
        return '{stall: s, valid: v, cnt: c};
    endfunction

    task automatic clear_d();
        flush = 0; d_wr_en = 0; d_wr_addr = 0; d_tnew = 0; d_rsel = 0;
        d_mtc0 = 0; d_rd = 0; d_eret = 0; d_rs = 0; d_rt = 0;
        d_use_rs = 0; d_use_rt = 0; d_tuse_rs = 0; d_tuse_rt = 0; d_md = 0; md_busy = 0;
    endtask

    task automatic test_reset();
        exp_a_t ea, oa;
        exp_b_t eb, ob;
        reset = 1;
        clear_d();
        d_wr_en = 1; d_wr_addr = 5'd9; d_tnew = 3'd3;
        repeat (2) @(negedge clk);
        clear_d();
        sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd0));
        sb_b.push_back(mk_b(0, 5'b00000, 3'd0));
        #1;
        ea = sb_a.pop_front();
        oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
        n_cmp++;
        if (oa !== ea) begin
            n_bad++;
            $display("FAIL reset_a: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                     oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
        end
        eb = sb_b.pop_front();
        ob = '{stall_d_b, st_valid_b, stall_cnt_b};
        n_cmp++;
        if (ob !== eb) begin
            n_bad++;
            $display("FAIL reset_b: got stall=%b valid=%b cnt=%0d, need stall=%b valid=%b cnt=%0d",
                     ob.stall, ob.valid, ob.cnt, eb.stall, eb.valid, eb.cnt);
        end
        reset = 0;
    endtask

    // lw $5 (tnew=2) followed by a consumer of $5 needed immediately.
    task automatic test_load_use();
        exp_a_t ea, oa;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_d();
            case (i)
                0: begin d_wr_en = 1; d_wr_addr = 5'd5; d_tnew = 3'd2; end
                1, 2, 3: begin d_use_rs = 1; d_rs = 5'd5; d_tuse_rs = 3'd0; end
                default: ;
            endcase
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd0));
                1: sb_a.push_back(mk_a(1, 3'b001, 3'b000, 15'd5, 32'd0));
                2: sb_a.push_back(mk_a(1, 3'b010, 3'b000, 15'd160, 32'd1));
                3: sb_a.push_back(mk_a(0, 3'b100, 3'b100, 15'd5120, 32'd2));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd2));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL load_use row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // ori $6 (tnew=1) then sw reading $6 with tuse_rt=2 and tuse_rs=1 (equal boundary).
    task automatic test_forward();
        exp_a_t ea, oa;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_d();
            case (i)
                0: begin d_wr_en = 1; d_wr_addr = 5'd6; d_tnew = 3'd1; end
                1: begin d_use_rt = 1; d_rt = 5'd6; d_tuse_rt = 3'd2;
                         d_use_rs = 1; d_rs = 5'd6; d_tuse_rs = 3'd1; end
                default: ;
            endcase
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd2));
                1: sb_a.push_back(mk_a(0, 3'b001, 3'b000, 15'd6, 32'd2));
                2: sb_a.push_back(mk_a(0, 3'b010, 3'b010, 15'd192, 32'd2));
                3: sb_a.push_back(mk_a(0, 3'b100, 3'b100, 15'd6144, 32'd2));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd2));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL forward row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // addu $0 must never be tracked, so a following $0 reader does not stall.
    task automatic test_zero_reg();
        exp_a_t ea, oa;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            clear_d();
            case (i)
                0: begin d_wr_en = 1; d_wr_addr = 5'd0; d_tnew = 3'd1; end
                1: begin d_use_rs = 1; d_rs = 5'd0; d_tuse_rs = 3'd0;
                         d_use_rt = 1; d_rt = 5'd0; d_tuse_rt = 3'd0; end
                default: ;
            endcase
            sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd2));
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL zero_reg row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // lw $7 (tnew=3) stalls a consumer; flush lands on the second stall cycle.
    task automatic test_flush();
        exp_a_t ea, oa;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_d();
            case (i)
                0: begin d_wr_en = 1; d_wr_addr = 5'd7; d_tnew = 3'd3; end
                1, 3: begin d_use_rs = 1; d_rs = 5'd7; end
                2: begin d_use_rs = 1; d_rs = 5'd7; flush = 1; end
                default: ;
            endcase
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd2));
                1: sb_a.push_back(mk_a(1, 3'b001, 3'b000, 15'd7, 32'd2));
                2: sb_a.push_back(mk_a(1, 3'b010, 3'b000, 15'd224, 32'd3));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd3));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL flush row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // Back-to-back mult/div ops: stage-0 md entry, then md_busy, then free.
    task automatic test_md();
        exp_a_t ea, oa;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            clear_d();
            if (i < 4) d_md = 1;
            if (i == 2) md_busy = 1;
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd3));
                1: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd3));
                2: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd4));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd5));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL md row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // Reset while both a load-use hazard and md_busy stall; only md_busy survives.
    task automatic test_reset_mid_stall();
        exp_a_t ea, oa;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            clear_d();
            case (i)
                0: begin d_wr_en = 1; d_wr_addr = 5'd5; d_tnew = 3'd2; end
                1: begin d_use_rs = 1; d_rs = 5'd5; d_md = 1; md_busy = 1; reset = 1; end
                2: begin d_use_rs = 1; d_rs = 5'd5; d_md = 1; md_busy = 1; reset = 0; end
                default: ;
            endcase
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd5));
                1: sb_a.push_back(mk_a(1, 3'b001, 3'b000, 15'd5, 32'd5));
                2: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd0));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd1));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL reset_mid_stall row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
        end
    endtask

    // mtc0 EPC then eret: 3 stall cycles on the 3-stage tracker, 5 on the 5-stage one.
    task automatic test_eret();
        exp_a_t ea, oa;
        exp_b_t eb, ob;
        @(negedge clk);
        clear_d();
        reset = 1;
        @(negedge clk);
        reset = 0;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            clear_d();
            if (i == 0) begin
                d_mtc0 = 1; d_rd = 5'd14;
            end else begin
                d_eret = 1;
            end
            case (i)
                0: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd0));
                1: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd0));
                2: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd1));
                3: sb_a.push_back(mk_a(1, 3'b000, 3'b000, 15'd0, 32'd2));
                default: sb_a.push_back(mk_a(0, 3'b000, 3'b000, 15'd0, 32'd3));
            endcase
            case (i)
                0: sb_b.push_back(mk_b(0, 5'b00000, 3'd0));
                6: sb_b.push_back(mk_b(0, 5'b00000, 3'd5));
                default: sb_b.push_back(mk_b(1, 5'b00000, 3'(i - 1)));
            endcase
            #1;
            ea = sb_a.pop_front();
            oa = '{stall_d_a, st_valid_a, st_fwd_ok_a, st_wr_addr_a, stall_cnt_a};
            n_cmp++;
            if (oa !== ea) begin
                n_bad++;
                $display("FAIL eret_a row %0d: got stall=%b valid=%b fwd=%b addr=%h cnt=%0d, need stall=%b valid=%b fwd=%b addr=%h cnt=%0d",
                         i, oa.stall, oa.valid, oa.fwd, oa.addr, oa.cnt, ea.stall, ea.valid, ea.fwd, ea.addr, ea.cnt);
            end
            eb = sb_b.pop_front();
            ob = '{stall_d_b, st_valid_b, stall_cnt_b};
            n_cmp++;
            if (ob !== eb) begin
                n_bad++;
                $display("FAIL eret_b row %0d: got stall=%b valid=%b cnt=%0d, need stall=%b valid=%b cnt=%0d",
                         i, ob.stall, ob.valid, ob.cnt, eb.stall, eb.valid, eb.cnt);
            end
        end
    endtask

    // 3-bit counter on the 5-stage tracker saturates at 7, then reset clears it.
    task automatic test_saturate();
        exp_b_t eb, ob;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_d();
            if (i < 5) begin
                d_md = 1; md_busy = 1;
            end
            reset = (i == 4);
            case (i)
                0: sb_b.push_back(mk_b(1, 5'b00000, 3'd5));
                1: sb_b.push_back(mk_b(1, 5'b00000, 3'd6));
                5: sb_b.push_back(mk_b(0, 5'b00000, 3'd0));
                default: sb_b.push_back(mk_b(1, 5'b00000, 3'd7));
            endcase
            #1;
            eb = sb_b.pop_front();
            ob = '{stall_d_b, st_valid_b, stall_cnt_b};
            n_cmp++;
            if (ob !== eb) begin
                n_bad++;
                $display("FAIL saturate row %0d: got stall=%b valid=%b cnt=%0d, need stall=%b valid=%b cnt=%0d",
                         i, ob.stall, ob.valid, ob.cnt, eb.stall, eb.valid, eb.cnt);
            end
        end
        reset = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_load_use();
        test_forward();
        test_zero_reg();
        test_flush();
        test_md();
        test_reset_mid_stall();
        test_eret();
        test_saturate();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
